// File: rtl/main_mem_pkg.sv
// main_mem_pkg: shared state type, MRW encodings and default
// geometry for the main-memory responder.
package main_mem_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_LINE_WORDS  = 4;
  localparam int DEF_WAIT_CYCLES = 3;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_DONE
  } state_e;

endpackage

// File: rtl/main_mem_responder_if.sv
// main_mem_responder_if: cache-to-memory request/response bundle
// (MStrobe/MRW side) with cache and memory views.
interface main_mem_responder_if
  import main_mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic [DATA_W-1:0] MDataOut;
  logic              MRdy;
  logic              MLast;
  logic              MBusy;

  modport master (
    output MStrobe, MRW, MAddr, MDataIn,
    input  MDataOut, MRdy, MLast, MBusy
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn,
    output MDataOut, MRdy, MLast, MBusy
  );

endinterface

// File: rtl/main_mem_responder_mem_array.sv
// mem_array: single-port word storage, synchronous write and
// combinational read; contents are never reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/main_mem_responder.sv
// main_mem_responder: fixed-latency memory responder returning
// line read bursts or committing single-word write-throughs.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int LINE_WORDS  = DEF_LINE_WORDS,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input logic           clk,
  input logic           reset,
  main_mem_responder_if.slave bus
);

  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

  localparam logic [OFF_W-1:0] LAST_BEAT =
    OFF_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_INIT =
    CNT_W'(WAIT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK =
    ~ADDR_W'(LINE_WORDS - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OFF_W-1:0]  beat_q, beat_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rdy_q, rdy_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [DATA_W-1:0] dout_q, dout_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mem_we  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.MStrobe) begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
          rw_d    = bus.MRW;
          wdata_d = bus.MDataIn;
          addr_d  = (bus.MRW == MEM_WRITE)
                  ? bus.MAddr
                  : (bus.MAddr & LINE_MASK);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          beat_d = '0;
          if (rw_q == MEM_WRITE) begin
            // reset on the commit edge wins over the write
            mem_we  = !reset;
            state_d = WR_DONE;
          end else begin
            state_d = RD_BURST;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RD_BURST: begin
        if (beat_q == LAST_BEAT) begin
          state_d = IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (reset) begin
      state_d = IDLE;
    end

    // beat index replaces the offset bits, so no carry upward
    mem_addr = mem_we ? addr_q
             : {addr_q[ADDR_W-1:OFF_W], beat_d};

    busy_d = (state_d != IDLE);
    rdy_d  = (state_d == RD_BURST) || (state_d == WR_DONE);
    last_d = (state_d == RD_BURST) && (beat_d == LAST_BEAT);
    dout_d = (state_d == RD_BURST) ? mem_rdata : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      rw_q    <= MEM_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign bus.MDataOut = dout_q;
  assign bus.MRdy     = rdy_q;
  assign bus.MLast    = last_q;
  assign bus.MBusy    = busy_q;

endmodule

// File: tb/tb_main_mem_responder.sv
// tb_main_mem_responder: two responders (default and W=1/L=8)
// checked cycle by cycle against a transaction-level model.
module tb_main_mem_responder;
  import main_mem_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  main_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if0 ();
  main_mem_responder_if #(.ADDR_W(8), .DATA_W(32)) if1 ();

  main_mem_responder #(
    .ADDR_W(8), .DATA_W(32),
    .LINE_WORDS(4), .WAIT_CYCLES(3)
  ) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );

  main_mem_responder #(
    .ADDR_W(8), .DATA_W(32),
    .LINE_WORDS(8), .WAIT_CYCLES(1)
  ) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  int errors = 0;
  int checks = 0;
  int sel    = 0;

  logic [31:0] mdl [2][256];
  logic [31:0] got_beats [8];

  typedef struct {
    int          s;
    logic        rw;
    logic [7:0]  a;
    logic [31:0] d;
    int          idx;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [8];

  task automatic check(input string nm,
                       input logic [34:0] got,
                       input logic [34:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic drive(input logic s, input logic rw,
                       input logic [7:0] a,
                       input logic [31:0] d);
    if0.MStrobe = s && (sel == 0);
    if1.MStrobe = s && (sel == 1);
    if0.MRW = rw;
    if1.MRW = rw;
    if0.MAddr = a;
    if1.MAddr = a;
    if0.MDataIn = d;
    if1.MDataIn = d;
  endtask

  function automatic logic [34:0] obs();
    if (sel == 0)
      return {if0.MBusy, if0.MRdy, if0.MLast, if0.MDataOut};
    return {if1.MBusy, if1.MRdy, if1.MLast, if1.MDataOut};
  endfunction

  task automatic poke(input int s, input int i,
                      input logic [31:0] v);
    if (s == 0) dut0.u_mem.mem_q[i] = v;
    else        dut1.u_mem.mem_q[i] = v;
    mdl[s][i] = v;
  endtask

  // One transaction, issued in the current (idle) cycle.
  // glitch: cycle with a stray conflicting request.
  // hold: keep the request asserted throughout.
  // abort_c: cycle in which reset is raised (0 = none).
  task automatic txn(input logic rw, input logic [7:0] a,
                     input logic [31:0] d, input int glitch,
                     input bit hold, input int abort_c);
    int w, l, n;
    logic [7:0]  base;
    logic [34:0] e, g;
    string nm;
    w = (sel == 1) ? 1 : 3;
    l = (sel == 1) ? 8 : 4;
    n = rw ? w + 1 : w + l;
    base = rw ? a : (a & ~8'(l - 1));
    drive(1'b1, rw, a, d);
    @(posedge clk);
    for (int c = 1; c <= n + 1; c++) begin
      @(negedge clk);
      if (hold)
        drive(1'b1, rw, a, d);
      else if (c == glitch)
        drive(1'b1, ~rw, 8'h40, 32'hBAD0BAD0);
      else
        drive(1'b0, rw, a, d);
      e = '0;
      if (c <= n) begin
        e[34] = 1'b1;
        if (rw && c == w + 1)
          e[33] = 1'b1;
        if (!rw && c > w) begin
          e[33] = 1'b1;
          e[32] = (c == w + l);
          e[31:0] = mdl[sel][8'(base + c - w - 1)];
        end
      end
      g = obs();
      if (!rw && c > w && c <= n)
        got_beats[c - w - 1] = g[31:0];
      nm = $sformatf("s%0d rw%0d a%02h c%0d",
                     sel, rw, a, c);
      check(nm, g, e);
      if (c == abort_c) begin
        reset = 1'b1;
        drive(1'b0, rw, a, d);
        @(negedge clk);
        check({nm, " reset"}, obs(), '0);
        reset = 1'b0;
        break;
      end
    end
    if (rw && (abort_c == 0 || abort_c > w))
      mdl[sel][a] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] orig;
    reset = 1'b1;
    sel = 0;
    drive(1'b0, 1'b0, '0, '0);
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 256; i++)
        poke(s, i, $urandom);
    for (int i = 0; i < 4; i++)
      poke(0, 8'h10 + i, 32'hA0 + i);
    for (int i = 0; i < 8; i++)
      poke(1, 8'hF8 + i, 32'h1000_00F8 + i);

    tbl[0] = '{0, 1'b0, 8'h12, 32'h0, 0, 32'hA0};
    tbl[1] = '{0, 1'b0, 8'h11, 32'h0, 3, 32'hA3};
    tbl[2] = '{0, 1'b1, 8'h25, 32'hDEADBEEF, -1, 32'h0};
    tbl[3] = '{0, 1'b0, 8'h24, 32'h0, 1, 32'hDEADBEEF};
    tbl[4] = '{0, 1'b1, 8'h10, 32'h12345678, -1, 32'h0};
    tbl[5] = '{0, 1'b0, 8'h13, 32'h0, 0, 32'h12345678};
    tbl[6] = '{1, 1'b0, 8'hFF, 32'h0, 7, 32'h1000_00FF};
    tbl[7] = '{1, 1'b0, 8'hFA, 32'h0, 0, 32'h1000_00F8};

    repeat (2) @(negedge clk);
    sel = 0;
    check("reset dut0", obs(), '0);
    sel = 1;
    check("reset dut1", obs(), '0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel = tbl[i].s;
      txn(tbl[i].rw, tbl[i].a, tbl[i].d, 0, 1'b0, 0);
      if (tbl[i].idx >= 0)
        check($sformatf("tbl%0d beat%0d", i, tbl[i].idx),
              {3'b0, got_beats[tbl[i].idx]},
              {3'b0, tbl[i].exp});
    end

    sel = 0;
    // stray write to 0x40 during WAIT must be ignored
    orig = mdl[0][8'h40];
    txn(1'b0, 8'h10, '0, 2, 1'b0, 0);
    txn(1'b0, 8'h40, '0, 0, 1'b0, 0);
    check("ignored req", {3'b0, got_beats[0]}, {3'b0, orig});

    txn(1'b0, 8'h20, '0, 0, 1'b1, 0);
    txn(1'b0, 8'h20, '0, 0, 1'b0, 0);

    txn(1'b0, 8'h10, '0, 0, 1'b0, 6);
    txn(1'b0, 8'h10, '0, 0, 1'b0, 0);

    orig = mdl[0][8'h30];
    txn(1'b1, 8'h30, 32'h55, 0, 1'b0, 2);
    txn(1'b1, 8'h31, 32'h66, 0, 1'b0, 3);
    txn(1'b1, 8'h32, 32'h77, 0, 1'b0, 4);
    txn(1'b0, 8'h30, '0, 0, 1'b0, 0);
    check("aborted wr", {3'b0, got_beats[0]}, {3'b0, orig});
    check("late reset wr", {3'b0, got_beats[2]},
          {3'b0, 32'h77});

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 1));
      txn(1'($urandom), 8'($urandom), $urandom,
          ($urandom_range(0, 3) == 0) ? 2 : 0, 1'b0, 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule

// File: doc/main_mem_responder.md
# main_mem_responder

Main-memory responder on the cache-to-memory interface (MStrobe/MRW side). It accepts one request at a time from the cache controller. After a fixed access latency it either returns a full cache line as a beat-per-cycle read burst or commits a single-word write-through. It holds the backing storage and is the only agent that drives MRdy, MLast and MDataOut.

## Interface
- ADDR_W, 8: word-address width; storage depth is 2**ADDR_W words.
- DATA_W, 32: word width.
- LINE_WORDS, 4: words per cache line and read-burst length; must be a power of two and at least 2.
- WAIT_CYCLES, 3: access latency in cycles; must be at least 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high; clears control state only, not storage.
- MStrobe  in  1  request from the cache controller; sampled only in IDLE.
- MRW  in  1  1 = write, 0 = read.
- MAddr  in  ADDR_W  word address.
- MDataIn  in  DATA_W  write data, sampled with MStrobe.
- MDataOut  out  DATA_W  read-beat data, valid while MRdy=1.
- MRdy  out  1  one pulse per read beat, or a single pulse for write completion.
- MLast  out  1  marks the final read beat; 0 for writes.
- MBusy  out  1  high from acceptance until the cycle after the last MRdy.

## Operation
- States: IDLE, WAIT, RD_BURST, WR_DONE.
- IDLE: MBusy=0. If MStrobe=1:
  - capture MRW, MAddr and MDataIn;
  - load the wait counter with WAIT_CYCLES-1;
  - go to WAIT.
  - Otherwise stay in IDLE.
- Read base address is line-aligned: the low log2(LINE_WORDS) bits of MAddr are forced to 0.
- Write uses MAddr unmodified.
- WAIT: decrement the counter every cycle. When it reaches 0:
  - read: go to RD_BURST with beat counter = 0;
  - write: write the captured word to storage on that edge, then go to WR_DONE.
- RD_BURST: each cycle, MRdy=1 and MDataOut = storage[base + beat]; the beat counter then increments.
  - MLast=1 when beat = LINE_WORDS-1, and the next state is IDLE.
  - The beat index stays within the line and never carries into the upper address bits.
- WR_DONE: MRdy=1 for one cycle, then IDLE.
- MStrobe, MRW, MAddr and MDataIn are ignored outside IDLE. A request held high across completion starts a new transaction on the next IDLE cycle.
- No back-pressure: the cache controller must accept every beat.
- Reset in any state forces IDLE on the next edge and aborts any burst.
  - A write aborted before the end of WAIT is not committed.
  - A write whose commit edge coincides with reset is not committed; reset has priority.
- Storage contents survive reset and are undefined after power-up. The bench preloads storage hierarchically.

## Timing
- Reset values: MRdy=0, MLast=0, MBusy=0, MDataOut=0, state=IDLE.
- All outputs are registered and decoded from the state register; there are no combinational paths from inputs to outputs.
- Acceptance edge = edge 0, with MStrobe=1 in IDLE.
- MBusy=1 in cycles 1 through the final MRdy cycle.
- Read:
  - WAIT occupies cycles 1..WAIT_CYCLES;
  - beats occur in cycles WAIT_CYCLES+1 .. WAIT_CYCLES+LINE_WORDS;
  - MLast is high in the final beat cycle.
- Write:
  - storage is updated at the end of cycle WAIT_CYCLES;
  - MRdy is high in cycle WAIT_CYCLES+1.
- Minimum one IDLE cycle between transactions. Back-to-back read period is WAIT_CYCLES+LINE_WORDS+1 cycles.
- Write-then-read of the same address returns the new data, because the write commits before the responder can accept another request.

## Structure
- Package main_mem_pkg holds:
  - the state enum (IDLE, WAIT, RD_BURST, WR_DONE);
  - MRW encodings (MEM_READ=1'b0, MEM_WRITE=1'b1);
  - the default parameter constants.
- Sub-module mem_array: single-port storage with synchronous write and combinational read, DEPTH=2**ADDR_W. It has no reset.
- The FSM, wait counter, beat counter and address/data capture live in main_mem_responder.

## Test plan
- Read burst (defaults): preload words 0x10..0x13 with 0xA0..0xA3, then MStrobe=1, MRW=0, MAddr=0x12 → MRdy high in cycles 4-7 with data 0xA0, 0xA1, 0xA2, 0xA3; MLast only in cycle 7; MBusy high in cycles 1-7.
- Write, then read back: MRW=1, MAddr=0x25, MDataIn=0xDEADBEEF → single MRdy in cycle 4 with MLast=0. A following read of line 0x24 returns 0xDEADBEEF on beat 1.
- Ignored request: MStrobe re-pulsed with MAddr=0x40 during WAIT of a read to 0x10 → only the 0x10 burst occurs. A held MStrobe starts the next transaction on the first IDLE cycle after completion.
- Reset mid-burst: reset in the cycle of beat 2 → all outputs are 0 next cycle and the state is IDLE. A subsequent read of the same line returns a complete four-beat burst.
- Aborted write: reset asserted in cycle 2 of a write of 0x55 to 0x30 → storage[0x30] unchanged and no MRdy pulse.
- Parameter sweep: WAIT_CYCLES=1 with LINE_WORDS=8 at address 0xFF → line base 0xF8; beats in cycles 2-9 read 0xF8..0xFF with no address carry.
